// File: rtl/pe_loader_pkg.sv
// Shared types and constants for the PE configuration loader: state encoding,
// config-word flag layout and the fixed flag patterns of each emitted word kind.
package pe_loader_pkg;

    localparam int FLAG_W     = 4;
    localparam int INST_W_DEF = 64;
    localparam int ID_W_DEF   = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_SWITCH  = 3'd2;
    localparam state_t ST_WAIT_GO = 3'd3;
    localparam state_t ST_START   = 3'd4;

    typedef struct packed {
        logic valid;
        logic w_switch;
        logic r_switch;
        logic start;
    } cfg_flags_t;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [ID_W_DEF-1:0]   id;
        cfg_flags_t            flags;
    } cfg_word_t;

    localparam cfg_flags_t FLAGS_IDLE   = 4'b0000;
    localparam cfg_flags_t FLAGS_LOAD   = 4'b1000;
    localparam cfg_flags_t FLAGS_SWITCH = 4'b0100;
    localparam cfg_flags_t FLAGS_START  = 4'b0011;

    localparam cfg_word_t IDLE_WORD = '0;

endpackage

// File: rtl/pe_config_loader_cfg_fifo.sv
// Command buffer for the PE config loader: synchronous FIFO of {inst, pe, last}
// with pointers one bit wider than the address to tell full from empty.
module cfg_fifo
    import pe_loader_pkg::*;
#(
    parameter int DATA_W = INST_W_DEF + ID_W_DEF + 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // Next pointer values; overflow and underflow requests are ignored.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i && !full_o) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_i && !empty_o) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written at the write pointer.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/pe_config_loader.sv
// Serialises host instruction commands into the 70-bit PE config word and sequences
// the w_switch / r_switch+start pulses. Optional counter: PE_LOADER_WORD_COUNT_EN.
module pe_config_loader #(
    parameter int INST_WIDTH = 64,
    parameter int ID         = 2,
    parameter int INST_WORD  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CONF       = INST_WIDTH + ID + 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [INST_WIDTH-1:0]             cmd_inst,
    input  logic [ID-1:0]                     cmd_pe,
    input  logic                              cmd_last,
    input  logic                              go,
    output logic                              busy,
    output logic [CONF-1:0]                   pe_config_out,
    output logic [$clog2(INST_WORD)+ID+1-1:0] word_cnt,
    output logic                              err_overflow
);

    import pe_loader_pkg::*;

    localparam int ENTRY_W = INST_WIDTH + ID + 1;
    localparam int CNT_W   = $clog2(INST_WORD) + ID + 1;

    logic                  rdy_q;
    logic                  push_s, pop_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [ENTRY_W-1:0]    fifo_data_s;
    logic [INST_WIDTH-1:0] head_inst_s;
    logic [ID-1:0]         head_pe_s;
    logic                  head_last_s;
    state_t                state_q, state_d;
    logic [CONF-1:0]       out_q, out_d;

    cfg_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .data_i  ({cmd_inst, cmd_pe, cmd_last}),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign {head_inst_s, head_pe_s, head_last_s} = fifo_data_s;

    // rdy_q keeps cmd_ready low while reset is held, even though the FIFO reads empty.
    assign cmd_ready     = rdy_q & ~fifo_full_s;
    assign push_s        = cmd_valid & cmd_ready;
    assign busy          = (state_q != ST_IDLE) | ~fifo_empty_s;
    assign pe_config_out = out_q;

    // Sequencer: picks the next word to emit and the next state.
    always_comb begin
        state_d = state_q;
        out_d   = '0;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    out_d   = {head_inst_s, head_pe_s, FLAGS_LOAD};
                    state_d = head_last_s ? ST_SWITCH : ST_LOAD;
                end else begin
                    out_d   = '0;
                    state_d = state_q;
                end
            end
            ST_SWITCH: begin
                out_d   = {{INST_WIDTH{1'b0}}, {ID{1'b0}}, FLAGS_SWITCH};
                state_d = ST_WAIT_GO;
            end
            ST_WAIT_GO: begin
                if (go) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_WAIT_GO;
                end
            end
            ST_START: begin
                out_d   = {{INST_WIDTH{1'b0}}, {ID{1'b0}}, FLAGS_START};
                state_d = ST_IDLE;
            end
            default: begin
                out_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, output word and ready-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rdy_q   <= 1'b1;
        end
    end

`ifdef PE_LOADER_WORD_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(INST_WORD << ID);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counts the words being emitted so the counter lines up with pe_config_out.
    always_comb begin
        cnt_d = cnt_q;
        if (out_d[0]) begin
            cnt_d = '0;
        end else if (out_d[3] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        err_d = err_q | (out_d[3] & (cnt_q >= LIMIT));
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign word_cnt     = cnt_q;
    assign err_overflow = err_q;
`else
    assign word_cnt     = {CNT_W{1'b0}};
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed self-checking bench for pe_config_loader (default parameters).
module tb_pe_config_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_last;
    logic        go;
    logic [63:0] cmd_inst;
    logic [1:0]  cmd_pe;
    logic        cmd_ready;
    logic        busy;
    logic [69:0] pe_config_out;
    logic [7:0]  word_cnt;
    logic        err_overflow;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PE_LOADER_WORD_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [69:0] W_IDLE = 70'd0;
    localparam logic [69:0] W_SW   = 70'b0100;
    localparam logic [69:0] W_ST   = 70'b0011;

    pe_config_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_inst      (cmd_inst),
        .cmd_pe        (cmd_pe),
        .cmd_last      (cmd_last),
        .go            (go),
        .busy          (busy),
        .pe_config_out (pe_config_out),
        .word_cnt      (word_cnt),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] w(input logic [63:0] inst, input logic [1:0] pe);
        return {inst, pe, 4'b1000};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [63:0] inst, input logic [1:0] pe, input logic last);
        cmd_inst  = inst;
        cmd_pe    = pe;
        cmd_last  = last;
        cmd_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_last = 1'b0; go = 1'b0;
        cmd_inst = 64'd0; cmd_pe = 2'd0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_out", pe_config_out, W_IDLE);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", cmd_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out", pe_config_out, W_IDLE);
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", cmd_ready, 1'b1);
        chk("idle_cnt", word_cnt, 8'd0);
        chk("idle_err", err_overflow, 1'b0);

        // single-command batch
        drive(64'hDEAD_BEEF_0000_0001, 2'd2, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("single_busy", busy, 1'b1);
        chk("single_pre", pe_config_out, W_IDLE);
        tick();
        chk("single_word", pe_config_out, {64'hDEAD_BEEF_0000_0001, 2'd2, 4'b1000});
        chk("single_cnt", word_cnt, CNT_EN ? 8'd1 : 8'd0);
        tick();
        chk("single_sw", pe_config_out, W_SW);
        tick();
        chk("single_wait", pe_config_out, W_IDLE);
        chk("wait_busy", busy, 1'b1);
        go = 1'b1; tick(); go = 1'b0;
        chk("single_go_edge", pe_config_out, W_IDLE);
        tick();
        chk("single_start", pe_config_out, W_ST);
        chk("start_cnt_clr", word_cnt, 8'd0);
        tick();
        chk("single_after", pe_config_out, W_IDLE);
        chk("single_busy_end", busy, 1'b0);

        // go ignored in IDLE and LOAD
        go = 1'b1; tick(); go = 1'b0;
        tick(); chk("go_idle_1", pe_config_out, W_IDLE);
        tick(); chk("go_idle_2", pe_config_out, W_IDLE);
        chk("go_idle_busy", busy, 1'b0);
        drive(64'h1111, 2'd1, 1'b0);
        tick(); cmd_valid = 1'b0;
        tick(); chk("load_a", pe_config_out, w(64'h1111, 2'd1));
        go = 1'b1; tick(); go = 1'b0;
        chk("go_load_1", pe_config_out, W_IDLE);
        tick(); chk("go_load_2", pe_config_out, W_IDLE);
        chk("load_busy", busy, 1'b1);
        drive(64'h2222, 2'd3, 1'b1);
        tick(); cmd_valid = 1'b0;
        tick(); chk("load_b", pe_config_out, w(64'h2222, 2'd3));
        chk("load_b_cnt", word_cnt, CNT_EN ? 8'd2 : 8'd0);
        tick(); chk("load_b_sw", pe_config_out, W_SW);
        tick(); chk("load_b_wait", pe_config_out, W_IDLE);
        go = 1'b1; tick(); go = 1'b0;
        tick(); chk("load_b_start", pe_config_out, W_ST);

        // prefetch in WAIT_GO until the FIFO fills
        drive(64'h3333, 2'd0, 1'b1);
        tick(); cmd_valid = 1'b0;
        tick(); chk("pf_c", pe_config_out, w(64'h3333, 2'd0));
        tick(); chk("pf_sw", pe_config_out, W_SW);
        for (int i = 0; i < 5; i++) begin
            drive(64'hA000 + 64'(i), 2'(i), (i == 4));
            if (i < 4) begin
                chk("pf_ready_hi", cmd_ready, 1'b1);
                tick();
                chk("pf_wait_out", pe_config_out, W_IDLE);
            end else begin
                chk("pf_ready_lo", cmd_ready, 1'b0);
            end
        end
        go = 1'b1; tick(); go = 1'b0;
        chk("pf_go_edge", pe_config_out, W_IDLE);
        chk("pf_full_g", cmd_ready, 1'b0);
        tick(); chk("pf_start", pe_config_out, W_ST);
        chk("pf_full_g1", cmd_ready, 1'b0);
        tick(); chk("pf_e0", pe_config_out, w(64'hA000, 2'd0));
        chk("pf_space", cmd_ready, 1'b1);
        tick(); cmd_valid = 1'b0;
        chk("pf_e1", pe_config_out, w(64'hA001, 2'd1));
        tick(); chk("pf_e2", pe_config_out, w(64'hA002, 2'd2));
        tick(); chk("pf_e3", pe_config_out, w(64'hA003, 2'd3));
        tick(); chk("pf_e4", pe_config_out, w(64'hA004, 2'd0));
        tick(); chk("pf_e4_sw", pe_config_out, W_SW);
        tick(); chk("pf_wait", pe_config_out, W_IDLE);
        go = 1'b1; tick(); go = 1'b0;
        tick(); chk("pf_start2", pe_config_out, W_ST);

        // overflow: 129 plain words then the last word, streamed back to back
        for (int i = 0; i < 130; i++) begin
            drive(64'(i), 2'd0, (i == 129));
            tick();
            chk("ovf_err", err_overflow, CNT_EN && (i >= 129));
            chk("ovf_cnt", word_cnt, CNT_EN ? 8'(i) : 8'd0);
        end
        cmd_valid = 1'b0;
        tick(); chk("ovf_last", pe_config_out, w(64'd129, 2'd0));
        chk("ovf_cnt_last", word_cnt, CNT_EN ? 8'd130 : 8'd0);
        chk("ovf_err_last", err_overflow, CNT_EN);
        tick(); chk("ovf_sw", pe_config_out, W_SW);
        tick();
        go = 1'b1; tick(); go = 1'b0;
        tick(); chk("ovf_start", pe_config_out, W_ST);
        chk("ovf_cnt_clr", word_cnt, 8'd0);
        chk("ovf_err_sticky", err_overflow, CNT_EN);

        // reset during LOAD with three entries still queued
        drive(64'h4444, 2'd1, 1'b1);
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            drive(64'hB000 + 64'(i), 2'd0, 1'b0);
            tick();
        end
        cmd_valid = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        tick(); chk("mr_start", pe_config_out, W_ST);
        tick(); chk("mr_e0", pe_config_out, w(64'hB000, 2'd0));
        chk("mr_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_out", pe_config_out, W_IDLE);
        chk("mr_busy", busy, 1'b0);
        chk("mr_ready", cmd_ready, 1'b0);
        chk("mr_err", err_overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_quiet", pe_config_out, W_IDLE);
        end
        chk("mr_busy_end", busy, 1'b0);
        chk("mr_ready_end", cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_config_loader.md
# pe_config_loader

Upstream feeder of the PE configuration chain. It accepts instruction words from the host/controller over a valid/ready handshake. It serialises them into the 70-bit `pe_config` word consumed by the first processing element, then sequences the instruction-memory bank-switch and start pulses that launch a loaded program. The first PE forwards the word down the chain one register per hop.

## Interface
- `INST_WIDTH`, default 64: instruction width.
- `ID`, default 2: PE-select field width.
- `INST_WORD`, default 32: instruction-memory depth per PE.
- `FIFO_DEPTH`, default 4: command buffer entries, power of two, ≥2.
- `CONF`, default `INST_WIDTH+ID+4`: config word width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: host command valid.
- `cmd_ready`, out, 1: high when FIFO not full.
- `cmd_inst`, in, `INST_WIDTH`: instruction.
- `cmd_pe`, in, `ID`: target PE id, placed unmodified in the id field.
- `cmd_last`, in, 1: last instruction of a batch.
- `go`, in, 1: launch request, single-cycle pulse.
- `busy`, out, 1: state ≠ IDLE or FIFO non-empty.
- `pe_config_out`, out, `CONF`: `{inst, id, valid, w_switch, r_switch, start}`, MSB first.
- `word_cnt`, out, `$clog2(INST_WORD)+ID+1`: words emitted in current batch.
- `err_overflow`, out, 1: sticky batch-overflow flag.

## Operation
- Handshake: a command is accepted on a clk edge with `cmd_valid && cmd_ready`. `cmd_ready` = FIFO not full, with no same-cycle full bypass. `cmd_valid` may be held high; data must be stable until accepted.
- FSM states:
  - **IDLE**: emits the idle word (all zero). If the FIFO is non-empty, pop and emit the entry, then go to LOAD, or to SWITCH if the entry has `last`.
  - **LOAD**: pops at most one entry per cycle. Each popped entry emits `{inst, pe, valid=1, 0, 0, 0}`. If the FIFO is empty, emit the idle word and stay. A popped entry with `last=1` → SWITCH.
  - **SWITCH**: emits one word `{0, 0, valid=0, w_switch=1, 0, 0}` → WAIT_GO.
  - **WAIT_GO**: emits the idle word with no pops. The host may prefetch the next batch into the FIFO. On `go` → START.
  - **START**: emits one word `{0, 0, 0, 0, r_switch=1, start=1}` → IDLE.
- `go` outside WAIT_GO is ignored and not remembered.
- The chain applies no backpressure; every emitted word is consumed.
- Reset values: `pe_config_out` = 0, `cmd_ready` = 0 during reset and 1 on the first cycle after release, `busy` = 0, `word_cnt` = 0, `err_overflow` = 0, FIFO empty, state IDLE.
- Reset mid-operation: the FIFO is flushed and the partial batch is discarded. No switch/start pulse is emitted. The downstream imem contents are undefined; the host reloads.

## Timing
- `pe_config_out` is fully registered.
- Latency: a command accepted at edge E, with the FIFO empty and the FSM in IDLE/LOAD, appears on `pe_config_out` after edge E+1.
- Throughput is one word per cycle in steady state. The FIFO never fills during streaming.
- The `last` word is followed by the w_switch word on the very next cycle.
- `go` sampled at edge G in WAIT_GO → the start word is visible after edge G+1.
- Each pulse word (w_switch, r_switch+start) is exactly one cycle wide.
- FIFO push and pop in the same cycle is legal whenever not full.

## Configuration
- `PE_LOADER_WORD_COUNT_EN` defined:
  - `word_cnt` increments per emitted valid word and saturates at all-ones.
  - It clears on the START word.
  - `err_overflow` sets when a batch exceeds `INST_WORD << ID` valid words. It stays set until reset.
  - Overflow words are still emitted.
- Undefined: `word_cnt` and `err_overflow` are tied to 0; the counter logic is absent. Ports remain in both builds.

## Structure
- Package `pe_loader_pkg` holds:
  - the state enum (IDLE, LOAD, SWITCH, WAIT_GO, START);
  - a packed struct for the config word fields;
  - field-width localparams;
  - the idle-word constant.
- Sub-module `cfg_fifo`: synchronous FIFO of `{inst, pe, last}`, `FIFO_DEPTH` entries, pointers one bit wider than the address for full/empty.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0 except `cmd_ready` = 1; `busy` = 0.
- Single command `cmd_inst = 64'hDEAD_BEEF_0000_0001`, `pe = 2`, `last = 1`:
  - the next cycle shows `pe_config_out = {64'hDEAD_BEEF_0000_0001, 2'd2, 4'b1000}`;
  - then `4'b0100` for one cycle;
  - `go` then yields `4'b0011` for one cycle, then 0.
- In WAIT_GO, push 5 back-to-back commands → `cmd_ready` drops after the 4th acceptance. After `go`, the 4 entries stream in order after START, and the 5th is accepted once space frees.
- Pulse `go` in LOAD and in IDLE → no start word; a later `go` in WAIT_GO works normally.
- With the macro: `INST_WORD = 32`, `ID = 2`, 129 valid words before `last` → `err_overflow` rises on the 129th emitted word and stays high through START. Without the macro → stays 0.
- Assert `rst_n` low for 1 cycle during LOAD with 3 entries queued → immediate zero output, FIFO empty, no w_switch or start emitted afterward.
